// File: rtl/pll_config_sequencer.sv
// pll_config_sequencer
// Moves the core clock off the PLL, reprograms the PLL while it is held in
// reset, waits for lock, and hands the core back to the PLL clock. Runs on the
// always-present external reference clock.

module pll_config_sequencer #(
    parameter int           SETTLE_CYCLES = 4,
    parameter int           LOCK_CYCLES   = 256,
    parameter int           CNT_W         = 9,
    parameter logic [4:0]   DIV_RST       = 5'd8
) (
    input  logic        clock,
    input  logic        resetb,

    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_div,
    input  logic [2:0]  cfg_sel,
    input  logic        cfg_dco,
    input  logic [25:0] cfg_trim,
    input  logic        cfg_bypass,
    output logic        cfg_err,

    input  logic        force_ext,

    output logic        pll_reset,
    output logic        pll_extclk_sel,
    output logic [4:0]  pll_div,
    output logic [2:0]  pll_sel,
    output logic        pll_dco,
    output logic [25:0] pll_trim,

    output logic        busy,
    output logic        locked
);

    // Sequence phases. IDLE is the only state that accepts a configuration.
    localparam logic [2:0] ST_IDLE   = 3'd0;  // waiting for a configuration
    localparam logic [2:0] ST_EXT    = 3'd1;  // core moved to external clock, settling
    localparam logic [2:0] ST_APPLY  = 3'd2;  // PLL in reset with new settings applied
    localparam logic [2:0] ST_LOCK   = 3'd3;  // PLL released, waiting for lock
    localparam logic [2:0] ST_SWITCH = 3'd4;  // core moved back to PLL clock, settling

    // Counter reload values; a phase of N cycles loads N-1 and ends at zero.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYCLES - 1);

    // Control state
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;

    // Registered PLL controls
    logic             pll_reset_q, pll_reset_d;
    logic             extclk_q, extclk_d;
    logic [4:0]       div_q, div_d;
    logic [2:0]       sel_q, sel_d;
    logic             dco_q, dco_d;
    logic [25:0]      trim_q, trim_d;

    // Configuration captured on the accepting edge
    logic [4:0]       lat_div_q;
    logic [2:0]       lat_sel_q;
    logic             lat_dco_q;
    logic [25:0]      lat_trim_q;
    logic             lat_bypass_q;

    logic             idle;
    logic             offer;
    logic             accept;
    logic             reject;
    logic             cnt_zero;

    assign idle      = (state_q == ST_IDLE);
    // run_q keeps the handshake closed until the first edge out of reset.
    assign cfg_ready = run_q && idle && !force_ext;
    assign offer     = cfg_valid && cfg_ready;
    assign accept    = offer && (cfg_div >= 5'd2);
    assign reject    = offer && (cfg_div <  5'd2);
    assign cnt_zero  = (cnt_q == '0);

    // Next-state and next-output computation for the sequencer.
    // NOTE: every _d signal is given its hold value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_zero ? cnt_q : cnt_q - 1'b1;
        err_d       = 1'b0;
        busy_d      = busy_q;
        locked_d    = locked_q;
        pll_reset_d = pll_reset_q;
        extclk_d    = extclk_q;
        div_d       = div_q;
        sel_d       = sel_q;
        dco_d       = dco_q;
        trim_d      = trim_q;

        if (force_ext) begin
            // Emergency fallback: the PLL settings themselves are left alone.
            extclk_d    = 1'b1;
            pll_reset_d = 1'b1;
            locked_d    = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        extclk_d = 1'b1;
                        locked_d = 1'b0;
                        busy_d   = 1'b1;
                        cnt_d    = SETTLE_LOAD;
                        state_d  = ST_EXT;
                    end else if (reject) begin
                        err_d = 1'b1;
                    end
                end

                ST_EXT: begin
                    if (cnt_zero) begin
                        // Core is safely on the external clock: reprogram now.
                        pll_reset_d = 1'b1;
                        div_d       = lat_div_q;
                        sel_d       = lat_sel_q;
                        dco_d       = lat_dco_q;
                        trim_d      = lat_trim_q;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = ST_APPLY;
                    end
                end

                ST_APPLY: begin
                    if (cnt_zero) begin
                        if (lat_bypass_q) begin
                            // Bypass leaves the PLL in reset and the core on ext clock.
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            pll_reset_d = 1'b0;
                            cnt_d       = LOCK_LOAD;
                            state_d     = ST_LOCK;
                        end
                    end
                end

                ST_LOCK: begin
                    if (cnt_zero) begin
                        extclk_d = 1'b0;
                        cnt_d    = SETTLE_LOAD;
                        state_d  = ST_SWITCH;
                    end
                end

                ST_SWITCH: begin
                    if (cnt_zero) begin
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a safe idle.
                    extclk_d    = 1'b1;
                    pll_reset_d = 1'b1;
                    locked_d    = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end
    end

    // Control and PLL-facing registers with synchronous active-low reset.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            extclk_q    <= 1'b1;
            div_q       <= DIV_RST;
            sel_q       <= '0;
            dco_q       <= 1'b0;
            trim_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
            err_q       <= err_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            pll_reset_q <= pll_reset_d;
            extclk_q    <= extclk_d;
            div_q       <= div_d;
            sel_q       <= sel_d;
            dco_q       <= dco_d;
            trim_q      <= trim_d;
        end
    end

    // Capture the offered configuration on the accepting edge.
    // NOTE: these payload registers have no reset; they are only read in EXT
    // and APPLY, which can only be reached after an accept has loaded them.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_div_q    <= cfg_div;
            lat_sel_q    <= cfg_sel;
            lat_dco_q    <= cfg_dco;
            lat_trim_q   <= cfg_trim;
            lat_bypass_q <= cfg_bypass;
        end
    end

    assign cfg_err        = err_q;
    assign busy           = busy_q;
    assign locked         = locked_q;
    assign pll_reset      = pll_reset_q;
    assign pll_extclk_sel = extclk_q;
    assign pll_div        = div_q;
    assign pll_sel        = sel_q;
    assign pll_dco        = dco_q;
    assign pll_trim       = trim_q;

endmodule

// File: tb/tb_pll_config_sequencer.sv
// Self-checking bench for pll_config_sequencer. Stimulus pushes time-stamped
// expectations into a scoreboard; a monitor on the falling edge pops and
// compares them against the DUT outputs.

module tb_pll_config_sequencer;

    logic        clock;
    logic        resetb;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_div;
    logic [2:0]  cfg_sel;
    logic        cfg_dco;
    logic [25:0] cfg_trim;
    logic        cfg_bypass;
    logic        cfg_err;
    logic        force_ext;
    logic        pll_reset;
    logic        pll_extclk_sel;
    logic [4:0]  pll_div;
    logic [2:0]  pll_sel;
    logic        pll_dco;
    logic [25:0] pll_trim;
    logic        busy;
    logic        locked;

    pll_config_sequencer dut (
        .clock          (clock),
        .resetb         (resetb),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_div        (cfg_div),
        .cfg_sel        (cfg_sel),
        .cfg_dco        (cfg_dco),
        .cfg_trim       (cfg_trim),
        .cfg_bypass     (cfg_bypass),
        .cfg_err        (cfg_err),
        .force_ext      (force_ext),
        .pll_reset      (pll_reset),
        .pll_extclk_sel (pll_extclk_sel),
        .pll_div        (pll_div),
        .pll_sel        (pll_sel),
        .pll_dco        (pll_dco),
        .pll_trim       (pll_trim),
        .busy           (busy),
        .locked         (locked)
    );

    typedef struct packed {
        logic [4:0]  div;
        logic [2:0]  sel;
        logic        dco;
        logic [25:0] trim;
    } cfg_t;

    typedef struct packed {
        logic        ready;
        logic        err;
        logic        rst;
        logic        ext;
        logic        busy;
        logic        locked;
        logic [4:0]  div;
        logic [2:0]  sel;
        logic        dco;
        logic [25:0] trim;
    } obs_t;

    typedef struct {
        int    due;
        string name;
        obs_t  exp;
        obs_t  mask;
    } chk_t;

    chk_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count rising edges; the monitor and stimulus refer to edges by this index.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
        end
    end

    function automatic obs_t ctl(logic r, logic e, logic rs, logic x, logic b, logic l);
        obs_t o;
        o = '0;
        o.ready = r; o.err = e; o.rst = rs; o.ext = x; o.busy = b; o.locked = l;
        return o;
    endfunction

    function automatic obs_t cfgv(cfg_t c);
        obs_t o;
        o = '0;
        o.div = c.div; o.sel = c.sel; o.dco = c.dco; o.trim = c.trim;
        return o;
    endfunction

    function automatic obs_t ctl_mask(logic with_ready);
        obs_t o;
        o = '0;
        o.ready = with_ready;
        o.err = 1'b1; o.rst = 1'b1; o.ext = 1'b1; o.busy = 1'b1; o.locked = 1'b1;
        return o;
    endfunction

    function automatic obs_t cfg_mask();
        obs_t o;
        o = '0;
        o.div = '1; o.sel = '1; o.dco = 1'b1; o.trim = '1;
        return o;
    endfunction

    // Insert an expectation, keeping the scoreboard ordered by due edge.
    task automatic push(input int due, input string name, input obs_t e, input obs_t m);
        chk_t c;
        int   i;
        c.due = due; c.name = name; c.exp = e; c.mask = m;
        i = 0;
        while (i < sb.size() && sb[i].due <= due) i++;
        sb.insert(i, c);
    endtask

    task automatic pk(input int a, input int k, input int max_k, input string tag,
                      input obs_t e, input obs_t m);
        if (k <= max_k) push(a + k, $sformatf("%s+%0d", tag, k), e, m);
    endtask

    // Expected timeline of a non-bypass sequence accepted at edge a.
    task automatic push_normal(input int a, input string tag, input cfg_t oldc,
                               input cfg_t newc, input logic rst0, input int max_k);
        obs_t fm;
        fm = ctl_mask(1'b1) | cfg_mask();
        pk(a, 0,   max_k, tag, ctl(0, 0, rst0, 1, 1, 0) | cfgv(oldc), fm);
        pk(a, 3,   max_k, tag, ctl(0, 0, rst0, 1, 1, 0) | cfgv(oldc), fm);
        pk(a, 4,   max_k, tag, ctl(0, 0, 1, 1, 1, 0)    | cfgv(newc), fm);
        pk(a, 7,   max_k, tag, ctl(0, 0, 1, 1, 1, 0)    | cfgv(newc), fm);
        pk(a, 8,   max_k, tag, ctl(0, 0, 0, 1, 1, 0)    | cfgv(newc), fm);
        pk(a, 263, max_k, tag, ctl(0, 0, 0, 1, 1, 0)    | cfgv(newc), fm);
        pk(a, 264, max_k, tag, ctl(0, 0, 0, 0, 1, 0)    | cfgv(newc), fm);
        pk(a, 267, max_k, tag, ctl(0, 0, 0, 0, 1, 0)    | cfgv(newc), fm);
        pk(a, 268, max_k, tag, ctl(1, 0, 0, 0, 0, 1)    | cfgv(newc), fm);
    endtask

    // Expected timeline of a bypass sequence accepted at edge b.
    task automatic push_bypass(input int b, input string tag, input cfg_t oldc, input cfg_t newc);
        obs_t fm;
        fm = ctl_mask(1'b1) | cfg_mask();
        for (int k = 0; k < 8; k++)
            pk(b, k, 8, tag, ctl(0, 0, 1, 1, 1, 0) | cfgv((k < 4) ? oldc : newc), fm);
        pk(b, 8, 8, tag, ctl(1, 0, 1, 1, 0, 0) | cfgv(newc), fm);
    endtask

    // Monitor: on each falling edge compare every expectation due at this edge.
    initial begin
        obs_t act;
        chk_t c;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clock);
            act.ready = cfg_ready; act.err = cfg_err; act.rst = pll_reset;
            act.ext = pll_extclk_sel; act.busy = busy; act.locked = locked;
            act.div = pll_div; act.sel = pll_sel; act.dco = pll_dco; act.trim = pll_trim;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                c = sb.pop_front();
                n_cmp++;
                if (c.due != cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for edge %0d reached only at edge %0d",
                             c.name, c.due, cyc);
                end else if ((act & c.mask) !== (c.exp & c.mask)) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got %h expected %h (rdy,err,rst,ext,busy,lck|div,sel,dco,trim)",
                             c.name, cyc, act & c.mask, c.exp & c.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic offer(input cfg_t c, input logic byp);
        cfg_valid  = 1'b1;
        cfg_div    = c.div;
        cfg_sel    = c.sel;
        cfg_dco    = c.dco;
        cfg_trim   = c.trim;
        cfg_bypass = byp;
    endtask

    initial begin
        cfg_t c_rst, c_a, c_b, c_c, c_byp, c_d, c_e;
        int   a, b;
        obs_t fm;

        c_rst = '{5'd8,  3'd0, 1'b0, 26'h0000000};
        c_a   = '{5'd8,  3'd1, 1'b0, 26'h0123456};
        c_b   = '{5'd16, 3'd2, 1'b0, 26'h0abcdef};
        c_c   = '{5'd12, 3'd4, 1'b0, 26'h0001111};
        c_byp = '{5'd5,  3'd3, 1'b1, 26'h3ffffff};
        c_d   = '{5'd20, 3'd5, 1'b1, 26'h02a2a2a};
        c_e   = '{5'd9,  3'd6, 1'b0, 26'h0000777};
        fm    = ctl_mask(1'b1) | cfg_mask();

        resetb = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_sel = '0; cfg_dco = 1'b0;
        cfg_trim = '0; cfg_bypass = 1'b0; force_ext = 1'b0;

        // Reset values, then idle with the handshake open.
        step();
        push(cyc + 1, "reset_hold", ctl(0, 0, 1, 1, 0, 0) | cfgv(c_rst), ctl_mask(1'b0) | cfg_mask());
        step();
        resetb = 1'b1;
        push(cyc + 1, "reset_release", ctl(1, 0, 1, 1, 0, 0) | cfgv(c_rst), fm);
        push(cyc + 3, "idle_after_reset", ctl(1, 0, 1, 1, 0, 0) | cfgv(c_rst), fm);
        step(); step(); step();

        // Normal sequence, div=8 sel=1.
        a = cyc + 1;
        offer(c_a, 1'b0);
        push_normal(a, "normal", c_rst, c_a, 1'b1, 268);
        step();
        cfg_valid = 1'b0;
        while (cyc < a + 268) step();

        // Rejected configurations (div=1, div=0) leave everything unchanged.
        for (int d = 1; d >= 0; d--) begin
            a = cyc + 1;
            offer(c_a, 1'b0);
            cfg_div = 5'(d);
            push(a,     $sformatf("reject_div%0d", d),      ctl(1, 1, 0, 0, 0, 1) | cfgv(c_a), fm);
            push(a + 1, $sformatf("reject_div%0d_end", d),  ctl(1, 0, 0, 0, 0, 1) | cfgv(c_a), fm);
            step();
            cfg_valid = 1'b0;
            step();
        end

        // Reconfigure from locked to div=16; pulses while busy are ignored.
        a = cyc + 1;
        offer(c_b, 1'b0);
        push_normal(a, "relock", c_a, c_b, 1'b0, 268);
        push(a + 2,   "busy_pulse_a", ctl(0, 0, 0, 1, 1, 0) | cfgv(c_a), fm);
        push(a + 150, "busy_pulse_b", ctl(0, 0, 0, 1, 1, 0) | cfgv(c_b), fm);
        step();
        while (cyc < a + 268) begin
            if (cyc + 1 == a + 2 || cyc + 1 == a + 150) begin
                cfg_valid = 1'b1;
                cfg_div   = (cyc + 1 == a + 2) ? 5'd3 : 5'd1;
            end else begin
                cfg_valid = 1'b0;
            end
            step();
        end
        cfg_valid = 1'b0;

        // force_ext at +100 with a bypass config pending; accept after release.
        a = cyc + 1;
        offer(c_c, 1'b0);
        push_normal(a, "pre_force", c_b, c_c, 1'b0, 99);
        step();
        cfg_valid = 1'b0;
        while (cyc + 1 < a + 100) step();
        force_ext = 1'b1;
        offer(c_byp, 1'b1);
        for (int k = 0; k < 3; k++)
            push(a + 100 + k, $sformatf("force+%0d", k), ctl(0, 0, 1, 1, 0, 0) | cfgv(c_c), fm);
        b = a + 103;
        push_bypass(b, "bypass", c_c, c_byp);
        step(); step(); step();
        force_ext = 1'b0;
        step();
        cfg_valid = 1'b0;
        while (cyc < b + 8) step();

        // resetb pulled low at +6, then a fresh sequence completes normally.
        a = cyc + 1;
        offer(c_d, 1'b0);
        push(a,     "rst_seq+0",  ctl(0, 0, 1, 1, 1, 0) | cfgv(c_byp), fm);
        push(a + 5, "rst_seq+5",  ctl(0, 0, 1, 1, 1, 0) | cfgv(c_d), fm);
        push(a + 6, "mid_reset",  ctl(0, 0, 1, 1, 0, 0) | cfgv(c_rst), ctl_mask(1'b0) | cfg_mask());
        push(a + 7, "post_reset", ctl(1, 0, 1, 1, 0, 0) | cfgv(c_rst), fm);
        step();
        cfg_valid = 1'b0;
        while (cyc + 1 < a + 6) step();
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        step();
        b = cyc + 1;
        offer(c_e, 1'b0);
        push_normal(b, "after_reset", c_rst, c_e, 1'b1, 268);
        step();
        cfg_valid = 1'b0;
        while (cyc < b + 268) step();

        // Drain any remaining expectations, bounded.
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
